// File: rtl/ifft_frame_sequencer.sv
// Frame sequencer between the 16-QAM mapper and the IFFT core: issues config
// words, frames the sample stream with tlast, limits frames in flight, and checks output frame length.
module ifft_frame_sequencer #(
  parameter int                NFFT         = 16,
  parameter int                LOG2N        = 4,
  parameter int                DW           = 32,
  parameter int                CFG_W        = 24,
  parameter logic [CFG_W-1:0]  CFG_DEFAULT  = 24'h340805,
  parameter int                MAX_INFLIGHT = 2
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [CFG_W-1:0] cfg_word,
  input  logic             cfg_update,
  output logic [CFG_W-1:0] m_cfg_tdata,
  output logic             m_cfg_tvalid,
  input  logic             m_cfg_tready,
  input  logic [DW-1:0]    s_sym_tdata,
  input  logic             s_sym_tvalid,
  output logic             s_sym_tready,
  output logic [DW-1:0]    m_fft_tdata,
  output logic             m_fft_tvalid,
  output logic             m_fft_tlast,
  input  logic             m_fft_tready,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  input  logic             mon_tlast,
  output logic [1:0]       inflight,
  output logic [15:0]      frames_in,
  output logic [15:0]      frames_out,
  output logic             len_err,
  output logic             cfg_busy
);

  typedef enum logic [1:0] {ST_CFG, ST_RUN, ST_DRAIN} state_t;

  localparam logic [1:0]       LP_MAX  = 2'(MAX_INFLIGHT);
  localparam logic [LOG2N-1:0] LP_LAST = LOG2N'(NFFT - 1);

  state_t           r_state;
  logic [CFG_W-1:0] r_cfg_data;
  logic             r_cfg_valid;
  logic [CFG_W-1:0] r_pend_word;
  logic             r_cfg_pending;
  logic             r_hold;
  logic [LOG2N-1:0] r_idx;
  logic [LOG2N-1:0] r_obeat;
  logic [1:0]       r_inflight;
  logic [15:0]      r_frames_in;
  logic [15:0]      r_frames_out;
  logic             r_len_err;

  logic w_open;
  logic w_dvalid;
  logic w_hs;
  logic w_inc;
  logic w_mon_hs;
  logic w_dec;

  // Gate ignores m_fft_tready so tvalid never depends on the core's ready.
  assign w_open   = (r_state == ST_RUN) &&
                    ((r_idx != '0) || r_hold ||
                     ((r_inflight < LP_MAX) && !r_cfg_pending));
  assign w_dvalid = s_sym_tvalid & w_open;
  assign w_hs     = w_dvalid & m_fft_tready;
  assign w_inc    = w_hs && (r_idx == LP_LAST);
  assign w_mon_hs = mon_tvalid & mon_tready;
  assign w_dec    = w_mon_hs & mon_tlast;

  assign m_fft_tdata  = s_sym_tdata;
  assign m_fft_tvalid = w_dvalid;
  assign s_sym_tready = m_fft_tready & w_open;
  assign m_fft_tlast  = (r_idx == LP_LAST);
  assign m_cfg_tdata  = r_cfg_data;
  assign m_cfg_tvalid = r_cfg_valid;
  assign inflight     = r_inflight;
  assign frames_in    = r_frames_in;
  assign frames_out   = r_frames_out;
  assign len_err      = r_len_err;
  assign cfg_busy     = (r_state != ST_RUN);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state       <= ST_CFG;
      r_cfg_data    <= CFG_DEFAULT;
      r_cfg_valid   <= 1'b1;
      r_pend_word   <= '0;
      r_cfg_pending <= 1'b0;
      r_hold        <= 1'b0;
      r_idx         <= '0;
      r_obeat       <= '0;
      r_inflight    <= '0;
      r_frames_in   <= '0;
      r_frames_out  <= '0;
      r_len_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_CFG: begin
          if (r_cfg_valid && m_cfg_tready) begin
            r_cfg_valid   <= 1'b0;
            r_cfg_pending <= 1'b0;
            r_state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if ((r_idx == '0) && r_cfg_pending && !r_hold)
            r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (r_inflight == '0) begin
            r_cfg_data  <= r_pend_word;
            r_cfg_valid <= 1'b1;
            r_state     <= ST_CFG;
          end
        end
        default: r_state <= ST_CFG;
      endcase

      // A request coinciding with the config handshake stays queued.
      if (cfg_update) begin
        r_pend_word   <= cfg_word;
        r_cfg_pending <= 1'b1;
      end

      if (w_hs)
        r_hold <= 1'b0;
      else if ((r_idx == '0) && w_dvalid)
        r_hold <= 1'b1;

      if (w_hs)
        r_idx <= (r_idx == LP_LAST) ? '0 : r_idx + 1'b1;

      if (w_inc) r_frames_in  <= r_frames_in + 16'd1;
      if (w_dec) r_frames_out <= r_frames_out + 16'd1;

      if (w_inc && !w_dec) begin
        r_inflight <= r_inflight + 2'd1;
      end else if (w_dec && !w_inc) begin
        if (r_inflight == '0)
          r_len_err <= 1'b1;
        else
          r_inflight <= r_inflight - 2'd1;
      end

      if (w_mon_hs) begin
        if (mon_tlast) begin
          if (r_obeat != LP_LAST) r_len_err <= 1'b1;
          r_obeat <= '0;
        end else if (r_obeat == LP_LAST) begin
          r_len_err <= 1'b1;
          r_obeat   <= '0;
        end else begin
          r_obeat <= r_obeat + 1'b1;
        end
      end
    end
  end

endmodule
